// File: rtl/serial_borrow_subtractor_16bit.sv
// ---------------------------------------------------------------------------
// serial_borrow_subtractor_16bit
//
// Bit-serial ripple-borrow subtractor: diff = in1 - in2 - b_in, one bit per
// clock, LSB first. A start pulse in IDLE captures the operands. WIDTH shift
// cycles follow, then a single-cycle done pulse. The results stay valid
// until the next operation finishes.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (aborts any operation)
//   start  : request, sampled only in IDLE
//   in1    : minuend, captured on the accepted start edge
//   in2    : subtrahend, captured on the accepted start edge
//   b_in   : borrow in, captured on the accepted start edge
//   busy   : high while in SHIFT or DONE
//   done   : one-cycle pulse marking the first cycle of a new valid result
//   diff   : difference modulo 2^WIDTH
//   b_out  : borrow out of the MSB (unsigned in1 < in2 + b_in)
//   ovf    : signed overflow (borrow into MSB xor borrow out of MSB)
// ---------------------------------------------------------------------------
module serial_borrow_subtractor_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-subtractor borrow: a - b - bi needs a borrow from the next bit.
    function automatic logic borrow_next(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    state_t             state_r;
    state_t             state_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // Holds the WIDTH-1 result bits produced so far. The final bit is merged
    // in directly on the finishing edge.
    logic [WIDTH-2:0]   dsr_r;
    logic               br_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [WIDTH-1:0]   diff_r;
    logic               b_out_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    logic               busy_s;
    logic               done_s;
    logic               last_bit_s;
    logic               res_bit_s;
    logic               br_next_s;
    logic [WIDTH-1:0]   dsr_ext_s;

    // Bit-slice arithmetic on the current LSBs of the operand shift registers.
    always_comb begin
        res_bit_s  = a_r[0] ^ b_r[0] ^ br_r;
        br_next_s  = borrow_next(a_r[0], b_r[0], br_r);
        last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
        // The new bit enters at the MSB side. After WIDTH shifts, the bit
        // from step i sits at index i.
        dsr_ext_s  = {res_bit_s, dsr_r};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode, computed from the next state so busy/done are registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_SHIFT: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Operand capture, serial datapath and final result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            dsr_r   <= {(WIDTH-1){1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            diff_r  <= {WIDTH{1'b0}};
            b_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= in1;
                        b_r   <= in2;
                        dsr_r <= {(WIDTH-1){1'b0}};
                        br_r  <= b_in;
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    dsr_r <= dsr_ext_s[WIDTH-1:1];
                    br_r  <= br_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        // br_r is the borrow into the MSB and br_next_s is
                        // the borrow out. Their xor is the signed overflow.
                        diff_r  <= dsr_ext_s;
                        b_out_r <= br_next_s;
                        ovf_r   <= br_r ^ br_next_s;
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign diff  = diff_r;
    assign b_out = b_out_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_serial_borrow_subtractor_16bit.sv
// ---------------------------------------------------------------------------
// Self-checking bench for serial_borrow_subtractor_16bit (WIDTH = 16).
// The expected values are hand-computed constants. A bench-side 16-bit
// ripple carry adder (in1 + ~in2 + ~b_in) cross-checks every result.
// ---------------------------------------------------------------------------
module tb_serial_borrow_subtractor_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        b_in;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    serial_borrow_subtractor_16bit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // 16-bit ripple carry adder computing in1 + ~in2 + ~b_in. It returns
    // {~carry_out, sum}, which equals {b_out, diff}.
    function automatic logic [16:0] adder_ref(input logic [15:0] x, input logic [15:0] y,
                                              input logic bi);
        logic [16:0] acc;
        logic        c;
        logic        yb;
        acc = 17'd0;
        c   = ~bi;
        for (int i = 0; i < 16; i++) begin
            yb     = ~y[i];
            acc[i] = x[i] ^ yb ^ c;
            c      = (x[i] & yb) | (c & (x[i] ^ yb));
        end
        acc[16] = ~c;
        return acc;
    endfunction

    // Runs one operation. It drives start for edge k, then scrambles the
    // operands. Start is pulsed again at edges k+g1 and k+g2 (0 = none).
    // lat is the first n with done high after edge k+n. busy_cnt counts busy
    // over n = 0..20. hold_ok tells whether the old results held for n < 16.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic bi,
                         input int g1, input int g2,
                         output int lat, output int pulses, output int busy_cnt,
                         output logic hold_ok);
        logic [15:0] d0;
        logic        bo0;
        logic        ov0;
        lat      = 0;
        pulses   = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        @(negedge clk);
        d0    = diff;
        bo0   = b_out;
        ov0   = ovf;
        in1   = x;
        in2   = y;
        b_in  = bi;
        start = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (busy) busy_cnt++;
            if (n < 16 && (diff !== d0 || b_out !== bo0 || ovf !== ov0)) hold_ok = 1'b0;
            in1   = ~x;
            in2   = ~y;
            b_in  = ~bi;
            start = ((n + 1) == g1) || ((n + 1) == g2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in1   = 16'h0000;
        in2   = 16'h0000;
        b_in  = 1'b0;
        #12;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== 16'h0000)  begin errors++; $display("FAIL reset_diff got %h want 0000", diff); end
        checks++; if (b_out !== 1'b0)     begin errors++; $display("FAIL reset_b_out got %b want 0", b_out); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // T1: basic subtraction and exact timing. done is high after edge k+16,
    // so the edge k+17 is the first edge that samples it.
    task automatic test_basic();
        int lat, pulses, bc;
        logic hold;
        logic [16:0] ar;
        do_op(16'd16245, 16'd3785, 1'b0, 0, 0, lat, pulses, bc, hold);
        ar = adder_ref(16'd16245, 16'd3785, 1'b0);
        checks++; if (diff !== 16'd12460) begin errors++; $display("FAIL t1_diff got %0d want 12460", diff); end
        checks++; if (b_out !== 1'b0)     begin errors++; $display("FAIL t1_b_out got %b want 0", b_out); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL t1_ovf got %b want 0", ovf); end
        checks++; if (lat != 16)          begin errors++; $display("FAIL t1_latency got %0d want 16", lat); end
        checks++; if (pulses != 1)        begin errors++; $display("FAIL t1_done_pulses got %0d want 1", pulses); end
        checks++; if (bc != 17)           begin errors++; $display("FAIL t1_busy_cycles got %0d want 17", bc); end
        checks++; if (hold !== 1'b1)      begin errors++; $display("FAIL t1_hold got %b want 1", hold); end
        checks++; if ({b_out, diff} !== ar) begin errors++; $display("FAIL t1_adder got %h want %h", {b_out, diff}, ar); end
    endtask

    // T2..T4: borrow, wrap and overflow corner cases.
    task automatic test_borrow_cases();
        logic [15:0] v1 [5];
        logic [15:0] v2 [5];
        logic        vb [5];
        logic [15:0] ed [5];
        logic        eb [5];
        logic        eo [5];
        int lat, pulses, bc;
        logic hold;
        logic [16:0] ar;
        v1 = '{16'd3785,  16'd530,   16'h8000, 16'h0000, 16'hFFFF};
        v2 = '{16'd16245, 16'd65005, 16'h0001, 16'h0000, 16'hFFFF};
        vb = '{1'b1,      1'b0,      1'b0,     1'b1,     1'b0};
        ed = '{16'd53075, 16'd1061,  16'h7FFF, 16'hFFFF, 16'h0000};
        eb = '{1'b1,      1'b1,      1'b0,     1'b1,     1'b0};
        eo = '{1'b0,      1'b0,      1'b1,     1'b0,     1'b0};
        for (int i = 0; i < 5; i++) begin
            do_op(v1[i], v2[i], vb[i], 0, 0, lat, pulses, bc, hold);
            ar = adder_ref(v1[i], v2[i], vb[i]);
            checks++; if (diff !== ed[i])  begin errors++; $display("FAIL case%0d_diff got %h want %h", i, diff, ed[i]); end
            checks++; if (b_out !== eb[i]) begin errors++; $display("FAIL case%0d_b_out got %b want %b", i, b_out, eb[i]); end
            checks++; if (ovf !== eo[i])   begin errors++; $display("FAIL case%0d_ovf got %b want %b", i, ovf, eo[i]); end
            checks++; if (lat != 16)       begin errors++; $display("FAIL case%0d_latency got %0d want 16", i, lat); end
            checks++; if ({b_out, diff} !== ar) begin errors++; $display("FAIL case%0d_adder got %h want %h", i, {b_out, diff}, ar); end
        end
    endtask

    // T5: start pulses at cycles 3 and 16 are ignored. Operand changes after
    // acceptance have no effect.
    task automatic test_start_while_busy();
        int lat, pulses, bc;
        logic hold;
        logic [16:0] ar;
        do_op(16'd40006, 16'd25530, 1'b0, 3, 16, lat, pulses, bc, hold);
        ar = adder_ref(16'd40006, 16'd25530, 1'b0);
        checks++; if (diff !== 16'd14476) begin errors++; $display("FAIL t5_diff got %0d want 14476", diff); end
        checks++; if (b_out !== 1'b0)     begin errors++; $display("FAIL t5_b_out got %b want 0", b_out); end
        checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL t5_ovf got %b want 1", ovf); end
        checks++; if (pulses != 1)        begin errors++; $display("FAIL t5_done_pulses got %0d want 1", pulses); end
        checks++; if (lat != 16)          begin errors++; $display("FAIL t5_latency got %0d want 16", lat); end
        checks++; if (bc != 17)           begin errors++; $display("FAIL t5_busy_cycles got %0d want 17", bc); end
        checks++; if (hold !== 1'b1)      begin errors++; $display("FAIL t5_hold got %b want 1", hold); end
        checks++; if ({b_out, diff} !== ar) begin errors++; $display("FAIL t5_adder got %h want %h", {b_out, diff}, ar); end
    endtask

    // T6: asynchronous abort in the middle of an operation, then recovery.
    task automatic test_abort();
        int lat, pulses, bc, late_done;
        logic hold;
        @(negedge clk);
        in1   = 16'd1000;
        in2   = 16'd1;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL t6_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL t6_done got %b want 0", done); end
        checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL t6_diff got %h want 0000", diff); end
        checks++; if (b_out !== 1'b0)    begin errors++; $display("FAIL t6_b_out got %b want 0", b_out); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL t6_ovf got %b want 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL t6_no_done got %0d want 0", late_done); end
        do_op(16'h1234, 16'h0234, 1'b0, 0, 0, lat, pulses, bc, hold);
        checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL t6_rerun_diff got %h want 1000", diff); end
        checks++; if (b_out !== 1'b0)    begin errors++; $display("FAIL t6_rerun_b_out got %b want 0", b_out); end
        checks++; if (lat != 16)         begin errors++; $display("FAIL t6_rerun_latency got %0d want 16", lat); end
    endtask

    // Start held high: the second operation is accepted at edge k+18 and
    // finishes with done high after edge k+34.
    task automatic test_back_to_back();
        int d1, d2, busy_low;
        logic [15:0] r1, r2;
        logic b1, b2, o1, o2;
        d1 = 0; d2 = 0; busy_low = 0;
        r1 = 16'h0000; r2 = 16'h0000;
        b1 = 1'b0; b2 = 1'b0; o1 = 1'b0; o2 = 1'b0;
        @(negedge clk);
        in1   = 16'h00FF;
        in2   = 16'h0100;
        b_in  = 1'b0;
        start = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                in1 = 16'h7FFF;
                in2 = 16'hFFFF;
                b_in = 1'b0;
            end
            if (n == 20) start = 1'b0;
            if (done && d1 == 0) begin
                d1 = n; r1 = diff; b1 = b_out; o1 = ovf;
            end else if (done && d2 == 0) begin
                d2 = n; r2 = diff; b2 = b_out; o2 = ovf;
            end
            if (n <= 34 && !busy) busy_low++;
        end
        checks++; if (d1 != 16)        begin errors++; $display("FAIL b2b_first_done got %0d want 16", d1); end
        checks++; if (d2 != 34)        begin errors++; $display("FAIL b2b_second_done got %0d want 34", d2); end
        checks++; if (busy_low != 1)   begin errors++; $display("FAIL b2b_idle_gap got %0d want 1", busy_low); end
        checks++; if (r1 !== 16'hFFFF) begin errors++; $display("FAIL b2b_diff1 got %h want ffff", r1); end
        checks++; if ({b1, o1} !== 2'b10) begin errors++; $display("FAIL b2b_flags1 got %b want 10", {b1, o1}); end
        checks++; if (r2 !== 16'h8000) begin errors++; $display("FAIL b2b_diff2 got %h want 8000", r2); end
        checks++; if ({b2, o2} !== 2'b11) begin errors++; $display("FAIL b2b_flags2 got %b want 11", {b2, o2}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_cases();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
